io_irq_ctrl: RTL and testbench

Interrupt controller between the I/O environment and the CPU. Latches timer ticks and button presses as pending events and arbitrates them by fixed priority. Presents one request at a time to the CPU with an irq/ack/eoi handshake and a per-source mask, so the CPU need not poll the input ports. Sits in the CPU environment beside the timer and the port decoder.

---
 rtl/io_irq_pkg.sv | 30 +++
 rtl/io_edge_sync.sv | 26 ++
 rtl/io_irq_ctrl.sv | 100 ++++++++++
 tb/tb_io_irq_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_irq_pkg.sv
// rtl/io_irq_pkg.sv - shared constants, FSM encoding and priority helper for io_irq_ctrl
package io_irq_pkg;

    localparam int NSRC       = 5;
    localparam int ID_W       = 3;
    localparam int SRC_TIMER  = 0;
    localparam int SRC_BTN0   = 1;
    localparam int SRC_BTN1   = 2;
    localparam int SRC_BTN2   = 3;
    localparam int SRC_BTN3   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    // Lowest set index wins; index 0 (timer) is highest priority.
    function automatic logic [ID_W-1:0] prio_pick(input logic [NSRC-1:0] req);
        logic [ID_W-1:0] pick;
        pick = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick = ID_W'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/io_edge_sync.sv
// rtl/io_edge_sync.sv - button synchronizer (reset to unpressed) with falling-edge pulse
module io_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/io_irq_ctrl.sv
// rtl/io_irq_ctrl.sv - latches timer/button events and hands them to the CPU one at a time
module io_irq_ctrl
    import io_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_timer,
    input  logic [3:0]      buttons,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_in,
    input  logic            ovf_clr,
    input  logic            irq_ack,
    input  logic            irq_eoi,
    output logic            irq,
    output logic [ID_W-1:0] irq_id,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask,
    output logic [NSRC-1:0] ovf
);

    logic [3:0]      btn_fall;
    logic            timer_prev;
    logic [NSRC-1:0] ev;
    logic [NSRC-1:0] grant_clr;
    logic [NSRC-1:0] eligible;
    irq_state_t      state, state_n;
    logic [ID_W-1:0] id_n;

    for (genvar b = 0; b < 4; b++) begin : g_btn
        io_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .reset(reset),
            .din  (buttons[b]),
            .fall (btn_fall[b])
        );
    end

    assign ev       = {btn_fall, i_timer & ~timer_prev};
    assign eligible = pending & ~mask;

    always_comb begin
        grant_clr = '0;
        if (state == ST_REQ && irq_ack) begin
            grant_clr[irq_id] = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        id_n    = irq_id;
        case (state)
            ST_IDLE: begin
                if (|eligible) begin
                    id_n    = prio_pick(eligible);
                    state_n = ST_REQ;
                end
            end
            // An ack in the same cycle as a mask change still completes the grant.
            ST_REQ: begin
                if (irq_ack) begin
                    state_n = ST_SERVICE;
                end else if (mask[irq_id]) begin
                    state_n = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (irq_eoi) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            irq        <= 1'b0;
            irq_id     <= '0;
            pending    <= '0;
            ovf        <= '0;
            mask       <= '1;
            timer_prev <= 1'b0;
        end else begin
            state      <= state_n;
            irq        <= (state_n == ST_REQ);
            irq_id     <= id_n;
            // New events override the grant clear; overflow only when the bit stays set.
            pending    <= (pending & ~grant_clr) | ev;
            ovf        <= (ovf & ~{NSRC{ovf_clr}}) | (ev & pending & ~grant_clr);
            timer_prev <= i_timer;
            if (mask_we) begin
                mask <= mask_in;
            end
        end
    end

endmodule

// File: tb/tb_io_irq_ctrl.sv
// tb/tb_io_irq_ctrl.sv - scoreboard bench for io_irq_ctrl
module tb_io_irq_ctrl;

    localparam logic [2:0] S_IRQ  = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_PEND = 3'd2;
    localparam logic [2:0] S_MASK = 3'd3;
    localparam logic [2:0] S_OVF  = 3'd4;

    typedef struct packed {
        logic [2:0] sig;
        logic [4:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_timer;
    logic [3:0] buttons;
    logic       mask_we;
    logic [4:0] mask_in;
    logic       ovf_clr;
    logic       irq_ack;
    logic       irq_eoi;
    logic       irq;
    logic [2:0] irq_id;
    logic [4:0] pending;
    logic [4:0] mask;
    logic [4:0] ovf;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    io_irq_ctrl #(.SYNC_STAGES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .i_timer(i_timer),
        .buttons(buttons),
        .mask_we(mask_we),
        .mask_in(mask_in),
        .ovf_clr(ovf_clr),
        .irq_ack(irq_ack),
        .irq_eoi(irq_eoi),
        .irq    (irq),
        .irq_id (irq_id),
        .pending(pending),
        .mask   (mask),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic sb_push(input logic [2:0] sig, input logic [4:0] val);
        exp_t e;
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain(input string step);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sig)
                S_IRQ:   check_val({step, ".irq"}, {4'b0, irq}, e.val);
                S_ID:    check_val({step, ".irq_id"}, {2'b0, irq_id}, e.val);
                S_PEND:  check_val({step, ".pending"}, pending, e.val);
                S_MASK:  check_val({step, ".mask"}, mask, e.val);
                default: check_val({step, ".ovf"}, ovf, e.val);
            endcase
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        tick(2);
        reset   = 1'b1;
    endtask

    task automatic set_mask(input logic [4:0] m);
        mask_we = 1'b1;
        mask_in = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic eoi_pulse();
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        i_timer = 1'b0;
        buttons = 4'hf;
        mask_we = 1'b0;
        mask_in = 5'b0;
        ovf_clr = 1'b0;
        irq_ack = 1'b0;
        irq_eoi = 1'b0;

        // Reset state, then timer pulse through a full handshake
        do_reset();
        sb_push(S_IRQ, 5'd0); sb_push(S_ID, 5'd0); sb_push(S_PEND, 5'd0);
        sb_push(S_MASK, 5'b11111); sb_push(S_OVF, 5'd0);
        sb_drain("reset");
        set_mask(5'b00000);
        i_timer = 1'b1;
        tick();
        i_timer = 1'b0;
        sb_push(S_PEND, 5'b00001); sb_push(S_IRQ, 5'd0);
        sb_drain("t1_latch");
        tick();
        sb_push(S_IRQ, 5'd1); sb_push(S_ID, 5'd0);
        sb_drain("t1_req");
        ack_pulse();
        sb_push(S_IRQ, 5'd0); sb_push(S_PEND, 5'd0);
        sb_drain("t1_ack");
        eoi_pulse();
        tick();
        sb_push(S_IRQ, 5'd0);
        sb_drain("t1_idle");

        // Timer and button 2 in the same cycle: timer first, then id 3
        buttons[2] = 1'b0;
        tick(2);
        i_timer = 1'b1;
        tick();
        i_timer = 1'b0;
        sb_push(S_PEND, 5'b01001);
        sb_drain("t2_latch");
        tick();
        sb_push(S_IRQ, 5'd1); sb_push(S_ID, 5'd0);
        sb_drain("t2_first");
        ack_pulse();
        sb_push(S_PEND, 5'b01000);
        sb_drain("t2_ack0");
        eoi_pulse();
        tick();
        sb_push(S_IRQ, 5'd1); sb_push(S_ID, 5'd3);
        sb_drain("t2_second");
        ack_pulse();
        sb_push(S_PEND, 5'd0); sb_push(S_IRQ, 5'd0);
        sb_drain("t2_ack3");
        eoi_pulse();
        buttons[2] = 1'b1;
        tick(3);

        // Button 0 pressed twice before ack: overflow, then clear
        buttons[0] = 1'b0;
        tick(3);
        buttons[0] = 1'b1;
        tick(3);
        buttons[0] = 1'b0;
        tick(3);
        sb_push(S_PEND, 5'b00010); sb_push(S_OVF, 5'b00010);
        sb_push(S_IRQ, 5'd1); sb_push(S_ID, 5'd1);
        sb_drain("t3_ovf");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        sb_push(S_OVF, 5'd0); sb_push(S_PEND, 5'b00010);
        sb_drain("t3_clr");
        ack_pulse();
        eoi_pulse();
        buttons[0] = 1'b1;
        tick(3);

        // Source 4 withdrawn by masking in REQ, re-requested on unmask
        buttons[3] = 1'b0;
        tick(4);
        sb_push(S_IRQ, 5'd1); sb_push(S_ID, 5'd4);
        sb_drain("t4_req");
        set_mask(5'b10000);
        sb_push(S_MASK, 5'b10000); sb_push(S_IRQ, 5'd1);
        sb_drain("t4_mask_we");
        tick();
        sb_push(S_IRQ, 5'd0); sb_push(S_PEND, 5'b10000);
        sb_drain("t4_withdraw");
        tick();
        sb_push(S_IRQ, 5'd0);
        sb_drain("t4_masked");
        set_mask(5'b00000);
        tick();
        sb_push(S_IRQ, 5'd1); sb_push(S_ID, 5'd4);
        sb_drain("t4_rereq");
        ack_pulse();
        eoi_pulse();
        buttons[3] = 1'b1;
        tick(3);

        // Reset in SERVICE with pending 00110, buttons held low across release
        buttons[0] = 1'b0;
        tick(4);
        ack_pulse();
        buttons[1] = 1'b0;
        buttons[0] = 1'b1;
        tick(3);
        buttons[0] = 1'b0;
        tick(3);
        sb_push(S_PEND, 5'b00110); sb_push(S_IRQ, 5'd0);
        sb_drain("t5_service");
        reset = 1'b0;
        tick();
        sb_push(S_IRQ, 5'd0); sb_push(S_ID, 5'd0); sb_push(S_PEND, 5'd0);
        sb_push(S_MASK, 5'b11111); sb_push(S_OVF, 5'd0);
        sb_drain("t5_reset");
        tick();
        reset = 1'b1;
        tick();
        sb_push(S_PEND, 5'd0);
        sb_drain("t5_rel1");
        tick();
        sb_push(S_PEND, 5'd0);
        sb_drain("t5_rel2");
        tick(3);
        sb_push(S_IRQ, 5'd0);
        sb_drain("t5_nomask");
        buttons = 4'hf;
        tick(3);
        do_reset();
        tick();

        // Timer event in the same cycle as ack of source 0
        set_mask(5'b00000);
        i_timer = 1'b1;
        tick();
        i_timer = 1'b0;
        tick();
        sb_push(S_IRQ, 5'd1); sb_push(S_ID, 5'd0);
        sb_drain("t6_req");
        irq_ack = 1'b1;
        i_timer = 1'b1;
        tick();
        irq_ack = 1'b0;
        i_timer = 1'b0;
        sb_push(S_PEND, 5'b00001); sb_push(S_OVF, 5'd0); sb_push(S_IRQ, 5'd0);
        sb_drain("t6_collide");
        eoi_pulse();
        tick();
        sb_push(S_IRQ, 5'd1); sb_push(S_ID, 5'd0);
        sb_drain("t6_regrant");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
